// File: rtl/dmem_stall_ctrl.sv
// dmem_stall_ctrl: fixed-latency data memory with pipeline stall control.
// Sits between EX/MEM and MEM/WB; holds the pipeline while an access runs.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   req_rd, req_wr  MEM-stage load / store request
//   addr, wdata     byte address, store data
//   rdata           registered load data
//   stall           freeze upstream stages, bubble into MEM/WB
//   done            access complete, rdata valid this cycle
//   err             sticky error (conflicting requests, misalignment)
//
// Build option: define DMEM_ALIGN_CHECK_EN to flag odd addresses as errors
// (access is suppressed but the stall/done timing is unchanged).
module dmem_stall_ctrl #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [15:0]             wdata_q;
    logic                    we_q;
    logic                    bad_q;
    logic                    err_q;
    logic [15:0]             rdata_q;

    logic                    accept;
    logic                    both;
    logic                    last;
    logic                    stall_c;
    logic                    misalign;
    logic                    mem_we;

    logic [15:0]             mem [DEPTH];

    // Only the word-index bits feed the array; the rest wrap away.
    logic unused_addr;
    assign unused_addr = ^addr;

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign = addr[0];
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        stall_c = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        both    = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_rd ^ req_wr) begin
                    accept  = 1'b1;
                    stall_c = 1'b1;
                    state_d = BUSY;
                end else if (req_rd & req_wr) begin
                    both = 1'b1;
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                if (cnt_q == 4'd0) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Same instruction still in MEM: requests are ignored here.
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A request held during reset must not raise stall.
    assign stall  = stall_c & rst;
    assign mem_we = last & we_q & ~bad_q;
    assign rdata  = rdata_q;
    assign err    = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 16'h0000;
            we_q    <= 1'b0;
            bad_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q   <= 4'(LATENCY - 1);
                idx_q   <= addr[DEPTH_LOG2:1];
                wdata_q <= wdata;
                we_q    <= req_wr;
                bad_q   <= misalign;
                if (misalign) err_q <= 1'b1;
            end else if (state_q == BUSY && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (both) err_q <= 1'b1;
            if (last && !we_q && !bad_q) rdata_q <= mem[idx_q];
        end
    end

    // Array is deliberately not reset; a reset aborts BUSY so no write lands.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx_q] <= wdata_q;
    end

endmodule
